// File: rtl/id_ex_pkg.sv
// Shared definitions for the decode->execute pipeline register.
// Control-bundle bit positions, default widths, NOP bubble value, skid state encoding.
package id_ex_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CTRL_W_DEF = 8;

    localparam int CTRL_MEMRD     = 0;
    localparam int CTRL_MEMWR     = 1;
    localparam int CTRL_REGWR     = 2;
    localparam int CTRL_ALUSRC    = 3;
    localparam int CTRL_ALUOP_LSB = 4;
    localparam int CTRL_ALUOP_W   = 4;

    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

    localparam logic [1:0] ST_EMPTY_ENC = 2'd0;
    localparam logic [1:0] ST_FULL_ENC  = 2'd1;
    localparam logic [1:0] ST_SKID_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = ST_EMPTY_ENC,
        ST_FULL  = ST_FULL_ENC,
        ST_SKID  = ST_SKID_ENC
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer on a packed payload with flush.
// Ports: clk, rst, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module pipe_skid_buf
    import id_ex_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         consume;

    // Ready is a pure decode of state: no path from out_ready.
    assign in_ready  = (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q <= in_data;
                        state  <= ST_SKID;
                    end else if (consume) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // Skid entry is older than anything still upstream.
                    if (consume) begin
                        main_q <= skid_q;
                        state  <= ST_FULL;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode->execute pipeline register: skid-buffered handshake, flush, NOP bubble.
// Ports: clk, rst, flush, in_* (decode side), out_* (execute side), hazard_stall.
// Build option: LOAD_USE_STALL_EN enables load-use stall against the held entry.
module id_ex_stage_reg
    import id_ex_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int MEMRD_BIT = CTRL_MEMRD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data_a,
    input  logic [DATA_W-1:0] in_data_b,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              hazard_stall
);

    localparam int W = PC_W + 3 * DATA_W + 3 * REG_AW + CTRL_W;

    logic [W-1:0]      pay_in;
    logic [W-1:0]      pay_out;
    logic [CTRL_W-1:0] ctrl_q;
    logic              buf_in_valid;
    logic              buf_in_ready;
    logic              load_in_main;
    logic              hazard;

    assign pay_in = {in_pc, in_data_a, in_data_b, in_imm,
                     in_rs, in_rt, in_rd, in_ctrl};

    assign {out_pc, out_data_a, out_data_b, out_imm,
            out_rs, out_rt, out_rd, ctrl_q} = pay_out;

    assign load_in_main = out_valid & ctrl_q[MEMRD_BIT]
                        & (out_rd != '0);

`ifdef LOAD_USE_STALL_EN
    assign hazard = load_in_main & in_valid
                  & ((in_rs == out_rd) | (in_rt == out_rd));
`else
    logic unused_load_in_main;
    assign unused_load_in_main = load_in_main;
    assign hazard = 1'b0;
`endif

    assign hazard_stall = hazard;
    assign buf_in_valid = in_valid & ~hazard;
    assign in_ready     = buf_in_ready & ~hazard;

    // Invalid slots leave the stage as a NOP so execute sees no side effects.
    assign out_ctrl = out_valid ? ctrl_q : CTRL_W'(NOP_CTRL);

    pipe_skid_buf #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus random scoreboard.
// Honours LOAD_USE_STALL_EN when defined for the build.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    ent_t        cur = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_data_a;
    logic [31:0] out_data_b;
    logic [31:0] out_imm;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [7:0]  out_ctrl;
    logic        hazard_stall;
    ent_t        obs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign obs = {out_pc, out_data_a, out_data_b, out_imm,
                  out_rs, out_rt, out_rd, out_ctrl};

    id_ex_stage_reg dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (cur.pc),
        .in_data_a    (cur.a),
        .in_data_b    (cur.b),
        .in_imm       (cur.imm),
        .in_rs        (cur.rs),
        .in_rt        (cur.rt),
        .in_rd        (cur.rd),
        .in_ctrl      (cur.ctrl),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_data_a   (out_data_a),
        .out_data_b   (out_data_b),
        .out_imm      (out_imm),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_ctrl     (out_ctrl),
        .hazard_stall (hazard_stall)
    );

    function automatic ent_t mk(input logic [31:0] pc, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [7:0] ctrl);
        ent_t e;
        e.pc   = pc;
        e.a    = pc ^ 32'h1111_0000;
        e.b    = pc + 32'h100;
        e.imm  = ~pc;
        e.rs   = rs;
        e.rt   = rt;
        e.rd   = rd;
        e.ctrl = ctrl;
        return e;
    endfunction

    function automatic ent_t rnd();
        ent_t e;
        e.pc   = $urandom;
        e.a    = $urandom;
        e.b    = $urandom;
        e.imm  = $urandom;
        e.rs   = 5'($urandom_range(0, 31));
        e.rt   = 5'($urandom_range(0, 31));
        e.rd   = 5'($urandom_range(0, 31));
        e.ctrl = 8'($urandom_range(0, 255));
        return e;
    endfunction

    // Inputs change at negedge and apply to the following posedge;
    // outputs are then observed 1ns later.
    task automatic drive(input ent_t e, input bit v, input bit rdy,
                         input bit fl, input bit r);
        @(negedge clk);
        cur       = e;
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
        rst       = r;
        #1;
    endtask

    task automatic test_reset();
        ent_t z = mk(0, 0, 0, 0, 0);
        drive(z, 0, 0, 0, 1);
        drive(z, 0, 0, 0, 1);
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL reset_valid got %b exp 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++;
            $display("FAIL reset_ready got %b exp 1", in_ready); end
        tests++; if (out_ctrl !== 8'h00) begin fails++;
            $display("FAIL reset_ctrl got %h exp 00", out_ctrl); end
        tests++; if (hazard_stall !== 1'b0) begin fails++;
            $display("FAIL reset_hazard got %b exp 0", hazard_stall); end
        tests++; if (out_pc !== 32'h0 || out_data_a !== 32'h0) begin fails++;
            $display("FAIL reset_data got %h/%h exp 0/0", out_pc, out_data_a); end
    endtask

    task automatic test_throughput();
        ent_t z = mk(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(mk(32'(4 * i), 1, 2, 3, 8'h04), 1, 1, 0, 0);
            if (i > 0) begin
                tests++;
                if (out_valid !== 1'b1 || out_pc !== 32'(4 * (i - 1)) ||
                    out_data_a !== (32'(4 * (i - 1)) ^ 32'h1111_0000) ||
                    in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_%0d got v=%b pc=%h a=%h rdy=%b exp v=1 pc=%h",
                             i, out_valid, out_pc, out_data_a, in_ready,
                             32'(4 * (i - 1)));
                end
            end
        end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'd28) begin fails++;
            $display("FAIL stream_last got v=%b pc=%h exp 1/1c", out_valid, out_pc); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin fails++;
            $display("FAIL stream_drain got v=%b ctrl=%h exp 0/00", out_valid, out_ctrl); end
    endtask

    task automatic test_skid();
        ent_t z = mk(0, 0, 0, 0, 0);
        drive(mk(32'h10, 1, 2, 3, 8'h04), 1, 0, 0, 0);
        tests++; if (in_ready !== 1'b1) begin fails++;
            $display("FAIL skid_rdy0 got %b exp 1", in_ready); end
        drive(mk(32'h14, 1, 2, 3, 8'h04), 1, 0, 0, 0);
        tests++; if (in_ready !== 1'b1 || out_pc !== 32'h10) begin fails++;
            $display("FAIL skid_rdy1 got rdy=%b pc=%h exp 1/10", in_ready, out_pc); end
        drive(mk(32'h18, 1, 2, 3, 8'h04), 1, 0, 0, 0);
        tests++; if (in_ready !== 1'b0 || out_pc !== 32'h10) begin fails++;
            $display("FAIL skid_full got rdy=%b pc=%h exp 0/10", in_ready, out_pc); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin fails++;
            $display("FAIL skid_out0 got v=%b pc=%h exp 1/10", out_valid, out_pc); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h14 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL skid_out1 got v=%b pc=%h rdy=%b exp 1/14/1",
                     out_valid, out_pc, in_ready); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_pc !== 32'h14) begin
            fails++;
            $display("FAIL skid_empty got v=%b ctrl=%h pc=%h exp 0/00/14",
                     out_valid, out_ctrl, out_pc); end
    endtask

    task automatic test_rst_mid();
        ent_t z = mk(0, 0, 0, 0, 0);
        drive(mk(32'h60, 1, 2, 3, 8'h04), 1, 0, 0, 0);
        drive(mk(32'h64, 1, 2, 3, 8'h04), 1, 0, 0, 0);
        drive(mk(32'h68, 1, 2, 3, 8'h04), 1, 0, 0, 1);
        tests++; if (in_ready !== 1'b0) begin fails++;
            $display("FAIL rstmid_full got %b exp 0", in_ready); end
        drive(z, 0, 0, 0, 0);
        tests++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1 ||
                     out_pc !== 32'h0) begin fails++;
            $display("FAIL rstmid got v=%b ctrl=%h rdy=%b pc=%h exp 0/00/1/0",
                     out_valid, out_ctrl, in_ready, out_pc); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL rstmid_after got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        ent_t z = mk(0, 0, 0, 0, 0);
        drive(mk(32'h30, 1, 2, 3, 8'h04), 1, 0, 0, 0);
        drive(mk(32'h34, 1, 2, 3, 8'h04), 1, 0, 0, 0);
        drive(mk(32'h20, 1, 2, 3, 8'h04), 1, 0, 1, 0);
        tests++; if (in_ready !== 1'b0 || out_pc !== 32'h30) begin fails++;
            $display("FAIL flush_pre got rdy=%b pc=%h exp 0/30", in_ready, out_pc); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++;
            $display("FAIL flush_skid got v=%b rdy=%b exp 0/1", out_valid, in_ready); end
        drive(mk(32'h38, 1, 2, 3, 8'h04), 1, 0, 0, 0);
        drive(mk(32'h24, 1, 2, 3, 8'h04), 1, 1, 1, 0);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h38 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_full got v=%b pc=%h rdy=%b exp 1/38/1",
                     out_valid, out_pc, in_ready); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin fails++;
            $display("FAIL flush_drop got v=%b ctrl=%h exp 0/00", out_valid, out_ctrl); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b0 || out_pc !== 32'h38) begin fails++;
            $display("FAIL flush_none got v=%b pc=%h exp 0/38", out_valid, out_pc); end
    endtask

    task automatic test_load_use();
        ent_t z    = mk(0, 0, 0, 0, 0);
        ent_t ld   = mk(32'h40, 1, 2, 5, 8'h05);
        ent_t dep  = mk(32'h44, 5, 3, 7, 8'h04);
        ent_t ld0  = mk(32'h50, 1, 2, 0, 8'h05);
        ent_t dep0 = mk(32'h54, 0, 0, 9, 8'h04);
        drive(ld, 1, 0, 0, 0);
        tests++; if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin fails++;
            $display("FAIL lu_load got hz=%b rdy=%b exp 0/1", hazard_stall, in_ready); end
`ifdef LOAD_USE_STALL_EN
        drive(dep, 1, 0, 0, 0);
        tests++; if (hazard_stall !== 1'b1 || in_ready !== 1'b0) begin fails++;
            $display("FAIL lu_stall0 got hz=%b rdy=%b exp 1/0", hazard_stall, in_ready); end
        drive(dep, 1, 0, 0, 0);
        tests++; if (hazard_stall !== 1'b1 || in_ready !== 1'b0) begin fails++;
            $display("FAIL lu_stall1 got hz=%b rdy=%b exp 1/0", hazard_stall, in_ready); end
        drive(dep, 1, 1, 0, 0);
        tests++; if (hazard_stall !== 1'b1 || out_pc !== 32'h40) begin fails++;
            $display("FAIL lu_consume got hz=%b pc=%h exp 1/40", hazard_stall, out_pc); end
        drive(dep, 1, 0, 0, 0);
        tests++; if (hazard_stall !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL lu_release got hz=%b rdy=%b v=%b exp 0/1/0",
                     hazard_stall, in_ready, out_valid); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h44) begin fails++;
            $display("FAIL lu_dep got v=%b pc=%h exp 1/44", out_valid, out_pc); end
`else
        drive(dep, 1, 0, 0, 0);
        tests++; if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin fails++;
            $display("FAIL lu_off got hz=%b rdy=%b exp 0/1", hazard_stall, in_ready); end
        drive(z, 0, 0, 0, 0);
        tests++; if (hazard_stall !== 1'b0 || in_ready !== 1'b0) begin fails++;
            $display("FAIL lu_off_skid got hz=%b rdy=%b exp 0/0", hazard_stall, in_ready); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_pc !== 32'h40) begin fails++;
            $display("FAIL lu_off_ld got pc=%h exp 40", out_pc); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h44) begin fails++;
            $display("FAIL lu_off_dep got v=%b pc=%h exp 1/44", out_valid, out_pc); end
`endif
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL lu_drain got %b exp 0", out_valid); end
        drive(ld0, 1, 0, 0, 0);
        drive(dep0, 1, 0, 0, 0);
        tests++; if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin fails++;
            $display("FAIL lu_r0 got hz=%b rdy=%b exp 0/1", hazard_stall, in_ready); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_pc !== 32'h50) begin fails++;
            $display("FAIL lu_r0_ld got pc=%h exp 50", out_pc); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h54) begin fails++;
            $display("FAIL lu_r0_dep got v=%b pc=%h exp 1/54", out_valid, out_pc); end
        drive(z, 0, 1, 0, 0);
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL lu_r0_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int   sent = 0;
        int   cyc  = 0;
        bit   v, r, f;
        bit   exp_v, exp_h, exp_r;
        while (sent < 10000 && cyc < 60000) begin
            e = rnd();
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 299) == 0);
            drive(e, v, r, f, 0);
            exp_v = (q.size() != 0);
            exp_h = 1'b0;
`ifdef LOAD_USE_STALL_EN
            if (exp_v && v)
                exp_h = q[0].ctrl[0] && (q[0].rd != 0) &&
                        (e.rs == q[0].rd || e.rt == q[0].rd);
`endif
            exp_r = (q.size() < 2) && !exp_h;
            tests++;
            if (out_valid !== exp_v) begin
                fails++;
                if (fails < 20) $display("FAIL rnd_valid cyc %0d got %b exp %b",
                                         cyc, out_valid, exp_v);
            end
            tests++;
            if (exp_v) begin
                if (obs !== q[0]) begin
                    fails++;
                    if (fails < 20) $display("FAIL rnd_payload cyc %0d got %h exp %h",
                                             cyc, obs, q[0]);
                end
            end else if (out_ctrl !== 8'h00) begin
                fails++;
                if (fails < 20) $display("FAIL rnd_bubble cyc %0d got %h exp 00",
                                         cyc, out_ctrl);
            end
            tests++;
            if (hazard_stall !== exp_h) begin
                fails++;
                if (fails < 20) $display("FAIL rnd_hazard cyc %0d got %b exp %b",
                                         cyc, hazard_stall, exp_h);
            end
            tests++;
            if (in_ready !== exp_r) begin
                fails++;
                if (fails < 20) $display("FAIL rnd_ready cyc %0d got %b exp %b",
                                         cyc, in_ready, exp_r);
            end
            if (exp_v && r) void'(q.pop_front());
            if (f) q.delete();
            else if (v && exp_r) begin
                q.push_back(e);
                sent++;
            end
            cyc++;
        end
        tests++;
        if (sent < 10000) begin
            fails++;
            $display("FAIL rnd_budget got %0d accepted exp 10000", sent);
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_skid();
        test_rst_mid();
        test_flush();
        test_load_use();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
